// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end of the word-wide data RAM.
//   - request size encodings
//   - controller state type
//   - byte-lane masks and a helper that places them on the addressed lanes
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_MERGE,
    ST_CAP
  } state_t;

  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  // Byte-enable mask for an access of the given size starting at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return LANE_MASK_BYTE << lane;
      SZ_HALF: return LANE_MASK_HALF << lane;
      default: return LANE_MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between the CPU side and the RAM word.
// Ports:
//   word       in  32  current RAM word (read data)
//   wdata      in  32  store data, LSB-justified
//   lane       in  2   byte offset within the word
//   size       in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_signed  in  1   sign-extend sub-word loads
//   load_data  out 32  extracted and extended load result
//   merge_data out 32  word with the addressed lane(s) replaced by wdata
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] ln,
                                              input logic [1:0] sz, input logic sgn);
    logic [31:0] sh;
    sh = w >> {ln, 3'b000};
    case (sz)
      SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] ln, input logic [1:0] sz);
    logic [3:0]  mask;
    logic [31:0] repl;
    logic [31:0] res;
    mask = lane_mask(sz, ln);
    // Replicate the store data across the word so every lane already holds
    // the right byte; the mask then picks which lanes take it.
    case (sz)
      SZ_BYTE: repl = {4{wd[7:0]}};
      SZ_HALF: repl = {2{wd[15:0]}};
      default: repl = wd;
    endcase
    res = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = repl[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    load_data  = load_extend(word, lane, size, is_signed);
    merge_data = store_merge(word, wdata, lane, size);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a word-wide single-port data RAM.
// Accepts byte/half/word CPU requests over valid/ready, converts them into
// RAM word accesses (read-modify-write for sub-word stores), and returns
// aligned, extended load data or an error for misaligned/out-of-range access.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_size, req_signed       store flag, size, sign-extend flag
//   req_addr, req_wdata                byte address, store data
//   rsp_valid, rsp_err, rsp_rdata      one-cycle response pulse, error, load data
//   ram_wEn, ram_addr, ram_dataIn      RAM write enable, word address, write data
//   ram_dataOut                        RAM read data
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [31:0]              rsp_rdata,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_dataIn,
  input  logic [31:0]              ram_dataOut
);

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("mem_access_ctrl: DATA_WIDTH must be 32 (four byte lanes)");
    end
  endgenerate

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [1:0]               lane_q;
  logic [1:0]               size_q;
  logic                     signed_q;
  logic                     we_q;
  logic [31:0]              wdata_q;
  logic [31:0]              din_q;
  logic [31:0]              load_data;
  logic [31:0]              merge_data;
  logic                     accept;
  logic                     req_err;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                          req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])         req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != '0) req_err = 1'b1;
    if ((req_addr >> (ADDRESS_WIDTH + 2)) != '0)    req_err = 1'b1;
  end

  mem_lane_align u_align (
    .word       (ram_dataOut),
    .wdata      (wdata_q),
    .lane       (lane_q),
    .size       (size_q),
    .is_signed  (signed_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !req_err) begin
          if (req_we && req_size == SZ_WORD) state_d = ST_WR;
          else                               state_d = ST_RD;
        end
      end
      ST_WR:    state_d = ST_IDLE;
      ST_RD:    state_d = we_q ? ST_MERGE : ST_CAP;
      ST_MERGE: state_d = ST_IDLE;
      ST_CAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write enable is decoded from state so reset kills an in-flight write at once.
  assign ram_wEn  = (state_q == ST_WR) || (state_q == ST_MERGE);
  assign ram_addr = addr_q;
  // The merged word depends on RAM read data in the MERGE cycle itself, so it
  // is driven combinationally there; din_q keeps the last driven value otherwise.
  assign ram_dataIn = (state_q == ST_MERGE) ? merge_data : din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      din_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (accept) begin
        lane_q   <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
        if (req_err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else begin
          addr_q <= req_addr[ADDRESS_WIDTH+1:2];
          if (req_we && req_size == SZ_WORD) din_q <= req_wdata;
        end
      end
      case (state_q)
        ST_WR:    rsp_valid <= 1'b1;
        ST_MERGE: begin
          rsp_valid <= 1'b1;
          din_q     <= merge_data;
        end
        ST_CAP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
